// File: rtl/tic_tac_toe.sv
// Tic-tac-toe engine: holds the 3x3 board, enforces turn order and move legality,
// and reports the game result combinationally from the board registers.
module tic_tac_toe (
  input  logic       clock,
  input  logic       reset,
  input  logic       play,
  input  logic       pc,
  input  logic [3:0] player_position,
  input  logic [3:0] computer_position,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [1:0] who
);

  typedef enum logic [1:0] {
    PLAYER_TURN   = 2'd0,
    COMPUTER_TURN = 2'd1,
    GAME_OVER     = 2'd2
  } state_t;

  localparam logic [1:0] EMPTY    = 2'b00;
  localparam logic [1:0] MARK_X   = 2'b01;
  localparam logic [1:0] MARK_O   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_board [9];

  logic       w_write_en;
  logic [3:0] w_write_idx;
  logic [1:0] w_write_val;
  logic       w_player_legal;
  logic       w_computer_legal;
  logic       w_x_wins;
  logic       w_o_wins;
  logic       w_full;

  // Legal target: in range 0..8 and currently empty; indices 9..15 never match.
  function automatic logic square_free(input logic [3:0] idx, input logic [1:0] board [9]);
    logic free;
    free = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (idx == 4'(i)) free = (board[i] == EMPTY);
    end
    return free;
  endfunction

  function automatic logic line_of(input logic [1:0] a, input logic [1:0] b,
                                   input logic [1:0] c, input logic [1:0] mark);
    return (a == mark) && (b == mark) && (c == mark);
  endfunction

  function automatic logic has_line(input logic [1:0] b [9], input logic [1:0] mark);
    return line_of(b[0], b[1], b[2], mark) || line_of(b[3], b[4], b[5], mark) ||
           line_of(b[6], b[7], b[8], mark) || line_of(b[0], b[3], b[6], mark) ||
           line_of(b[1], b[4], b[7], mark) || line_of(b[2], b[5], b[8], mark) ||
           line_of(b[0], b[4], b[8], mark) || line_of(b[2], b[4], b[6], mark);
  endfunction

  always_comb begin
    w_x_wins = has_line(r_board, MARK_X);
    w_o_wins = has_line(r_board, MARK_O);
    w_full   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (r_board[i] == EMPTY) w_full = 1'b0;
    end
    // Player priority if both lines ever coexist; a ninth-move win beats draw.
    if (w_x_wins)      who = MARK_X;
    else if (w_o_wins) who = MARK_O;
    else if (w_full)   who = RES_DRAW;
    else               who = EMPTY;
  end

  assign w_player_legal   = square_free(player_position, r_board);
  assign w_computer_legal = square_free(computer_position, r_board);

  // NOTE: every signal driven here gets a default first so no latch is inferred
  // on paths (illegal move, wrong turn) that do not assign it.
  always_comb begin
    w_state_next = r_state;
    w_write_en   = 1'b0;
    w_write_idx  = 4'd0;
    w_write_val  = EMPTY;
    // A decided board accepts no further moves, including the cycle before GAME_OVER.
    unique case (r_state)
      PLAYER_TURN: begin
        if (who != EMPTY) begin
          w_state_next = GAME_OVER;
        end else if (play && w_player_legal) begin
          w_write_en   = 1'b1;
          w_write_idx  = player_position;
          w_write_val  = MARK_X;
          w_state_next = COMPUTER_TURN;
        end
      end
      COMPUTER_TURN: begin
        if (who != EMPTY) begin
          w_state_next = GAME_OVER;
        end else if (pc && w_computer_legal) begin
          w_write_en   = 1'b1;
          w_write_idx  = computer_position;
          w_write_val  = MARK_O;
          w_state_next = PLAYER_TURN;
        end
      end
      GAME_OVER: w_state_next = GAME_OVER;
      default:   w_state_next = PLAYER_TURN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= PLAYER_TURN;
    else        r_state <= w_state_next;
  end

  // NOTE: the board is nine 2-bit registers, not a RAM, so it is reset
  // directly; the display must show an empty board while reset is held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 9; i++) r_board[i] <= EMPTY;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (w_write_en && (w_write_idx == 4'(i))) r_board[i] <= w_write_val;
      end
    end
  end

  assign pos1 = r_board[0];
  assign pos2 = r_board[1];
  assign pos3 = r_board[2];
  assign pos4 = r_board[3];
  assign pos5 = r_board[4];
  assign pos6 = r_board[5];
  assign pos7 = r_board[6];
  assign pos8 = r_board[7];
  assign pos9 = r_board[8];

endmodule

// File: tb/tb_tic_tac_toe.sv
// Bench for tic_tac_toe: directed game scenarios plus random move streams,
// compared against a behavioural game model after every clock edge.
module tb_tic_tac_toe;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       play  = 1'b0;
  logic       pc    = 1'b0;
  logic [3:0] player_position   = 4'd0;
  logic [3:0] computer_position = 4'd0;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who;
  logic [1:0] w_pos [9];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: 0 empty, 1 player, 2 computer; turn 0 = player, 1 = computer.
  int m_board [9];
  int m_turn;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  tic_tac_toe dut (
    .clock(clock), .reset(reset), .play(play), .pc(pc),
    .player_position(player_position), .computer_position(computer_position),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9), .who(who)
  );

  assign w_pos = '{pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};

  always #5 clock = ~clock;

  function automatic int m_result();
    bit p_win, c_win, full;
    p_win = 0; c_win = 0; full = 1;
    foreach (lines[l]) begin
      if (m_board[lines[l][0]] == 1 && m_board[lines[l][1]] == 1 && m_board[lines[l][2]] == 1) p_win = 1;
      if (m_board[lines[l][0]] == 2 && m_board[lines[l][1]] == 2 && m_board[lines[l][2]] == 2) c_win = 1;
    end
    foreach (m_board[i]) if (m_board[i] == 0) full = 0;
    if (p_win) return 1;
    if (c_win) return 2;
    if (full)  return 3;
    return 0;
  endfunction

  task automatic m_clear();
    foreach (m_board[i]) m_board[i] = 0;
    m_turn = 0;
  endtask

  task automatic check_all(input string tag);
    logic [1:0] exp;
    for (int i = 0; i < 9; i++) begin
      exp = 2'(m_board[i]);
      n_checks++;
      assert (w_pos[i] === exp) else begin
        n_fail++;
        $error("FAIL %s pos%0d got %b expected %b", tag, i + 1, w_pos[i], exp);
      end
    end
    exp = 2'(m_result());
    n_checks++;
    assert (who === exp) else begin
      n_fail++;
      $error("FAIL %s who got %b expected %b", tag, who, exp);
    end
  endtask

  task automatic step(input logic p, input logic c, input int pp, input int cp, input string tag);
    play = p; pc = c;
    player_position   = 4'(pp);
    computer_position = 4'(cp);
    @(posedge clock);
    #1;
    if (m_result() == 0) begin
      if (m_turn == 0) begin
        if (p && pp <= 8) begin
          if (m_board[pp] == 0) begin m_board[pp] = 1; m_turn = 1; end
        end
      end else begin
        if (c && cp <= 8) begin
          if (m_board[cp] == 0) begin m_board[cp] = 2; m_turn = 0; end
        end
      end
    end
    check_all(tag);
  endtask

  task automatic mv_p(input int idx, input string tag); step(1'b1, 1'b0, idx, 0, tag); endtask
  task automatic mv_c(input int idx, input string tag); step(1'b0, 1'b1, 0, idx, tag); endtask

  // Reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic apply_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    #1;
    m_clear();
    check_all(tag);
    @(posedge clock);
    #1;
    check_all({tag, "_held"});
    reset = 1'b1;
  endtask

  initial begin
    m_clear();
    #12;
    check_all("por");
    reset = 1'b1;

    // 1: computer cannot move first
    mv_c(4, "t1_pc_first");
    n_checks++;
    assert (pos5 === 2'b00) else begin
      n_fail++;
      $error("FAIL t1_pos5 got %b expected 00", pos5);
    end

    // 2: player row win, then frozen
    mv_p(0, "t2_p0"); mv_c(4, "t2_c4"); mv_p(1, "t2_p1"); mv_c(8, "t2_c8"); mv_p(2, "t2_p2");
    n_checks++;
    assert (who === 2'b01) else begin
      n_fail++;
      $error("FAIL t2_who got %b expected 01", who);
    end
    step(1'b1, 1'b1, 5, 6, "t2_frozen_a");
    step(1'b1, 1'b1, 3, 7, "t2_frozen_b");
    mv_c(5, "t2_frozen_c");

    // 3: illegal moves rejected
    apply_reset("t3_reset");
    mv_p(0, "t3_p0"); mv_c(4, "t3_c4"); mv_p(0, "t3_occupied"); mv_p(9, "t3_range");
    mv_c(5, "t3_wrong_turn"); mv_p(1, "t3_p1");

    // 4: computer anti-diagonal win
    apply_reset("t4_reset");
    mv_p(0, "t4_p0"); mv_c(2, "t4_c2"); mv_p(1, "t4_p1"); mv_c(4, "t4_c4");
    mv_p(8, "t4_p8"); mv_c(6, "t4_c6");
    n_checks++;
    assert (who === 2'b10) else begin
      n_fail++;
      $error("FAIL t4_who got %b expected 10", who);
    end
    mv_p(3, "t4_frozen");

    // 5: draw
    apply_reset("t5_reset");
    mv_p(0, "t5_1"); mv_c(1, "t5_2"); mv_p(2, "t5_3"); mv_c(4, "t5_4"); mv_p(3, "t5_5");
    mv_c(5, "t5_6"); mv_p(7, "t5_7"); mv_c(6, "t5_8"); mv_p(8, "t5_9");
    n_checks++;
    assert (who === 2'b11) else begin
      n_fail++;
      $error("FAIL t5_who got %b expected 11", who);
    end

    // 6: reset during move 3
    apply_reset("t6_reset0");
    mv_p(0, "t6_p0"); mv_c(4, "t6_c4");
    play = 1'b1; player_position = 4'd1;
    apply_reset("t6_midmove");
    mv_p(4, "t6_newgame");

    // Random move streams, resetting once each game is decided.
    for (int g = 0; g < 40; g++) begin
      int steps_after;
      steps_after = 0;
      apply_reset("rnd_reset");
      for (int s = 0; s < 40 && steps_after < 3; s++) begin
        int pp, cp;
        pp = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 8)) : int'($urandom_range(9, 15));
        cp = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 8)) : int'($urandom_range(9, 15));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pp, cp, "rnd");
        if (m_result() != 0) steps_after++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
